down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
- Programmable, loadable down-counter/timer. It is the counting-down counterpart of the team's free-running 4-bit up counter.
- Software or an FSM loads a start value, starts the count, and can pause or abort it.
- Asserts a one-cycle terminal-count pulse when the count expires.
- Supports one-shot and auto-reload (periodic tick) modes, for use as a delay or timeout generator beside the existing counters.

Parameters:
- WIDTH, 4, bit width of load value and count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- load  input  1  capture load_val into the reload register and the count.
- load_val  input  WIDTH  start/reload value.
- start  input  1  begin counting from the current count.
- pause  input  1  level; freezes the count while high.
- stop  input  1  abort the run; count is held, no tc.
- auto_reload  input  1  level; 1 = periodic mode, 0 = one-shot.
- count  output  WIDTH  current count value (registered).
- busy  output  1  high in RUN or HOLD.
- tc  output  1  terminal-count pulse, one cycle, registered.
- err  output  1  one-cycle pulse on an illegal start (count == 0).

Behaviour:
- Reset: when reset == 0 at a clk edge:
  - state = IDLE; count = 0; reload_reg = 0; busy = 0; tc = 0; err = 0.
  - Reset overrides every other input, including mid-run.
- States: IDLE, RUN, HOLD. busy = 1 exactly when state is RUN or HOLD; busy is registered with the state.
- tc and err default to 0 every cycle; each is high only in the cycle after the edge that sets it.
- IDLE:
  - If load = 1: reload_reg <= load_val and count <= load_val.
  - Else, if start = 1 and count != 0: state -> RUN. Count is not decremented on that edge.
  - If start = 1 and count == 0: stay IDLE, err <= 1.
  - load has priority over start when both are high in the same cycle: the value is loaded and start is ignored.
  - stop and pause are ignored in IDLE.
- RUN, evaluated at each edge in priority order stop > pause > decrement:
  - stop = 1: state -> IDLE, count held, tc stays 0.
  - pause = 1: state -> HOLD, count held.
  - Else if count > 1: count <= count - 1.
  - Else (count == 1):
    - auto_reload = 0: count <= 0, tc <= 1, state -> IDLE.
    - auto_reload = 1: count <= reload_reg, tc <= 1, stay RUN. If reload_reg is 0 (only reachable via a mid-run reset race, which cannot occur), count <= 0 and state -> IDLE.
- HOLD:
  - stop = 1: state -> IDLE, count held.
  - pause = 0: state -> RUN with no decrement on that edge.
  - Otherwise stay HOLD.
- load is ignored in RUN and HOLD; reload_reg and count are unchanged.
- auto_reload is sampled only at the expiry edge; it may change mid-run.
- Latency:
  - start sampled at edge k with count = N: count reads N-1 after edge k+1.
  - tc is high during the cycle after edge k+N.
  - In one-shot mode busy falls at that same edge.
  - Periodic mode: one tc every N cycles, first one after edge k+N.
- Arithmetic: unsigned, WIDTH bits. Decrement never goes below 0 and never wraps. The maximum count is 2^WIDTH - 1 (15 at default).
- Abort then restart: after stop, a start resumes from the held count. A load issued first replaces it.

Test Plan:
- Reset: hold reset=0 for 2 edges, with load=1 and load_val=9 asserted -> count=0, busy=0, tc=0, err=0; the load is ignored.
- One-shot: load 5, then start -> count sequence 5,4,3,2,1,0; tc high exactly one cycle, 5 cycles after the start edge; busy drops with tc; count stays 0 afterwards.
- Periodic: load 3, auto_reload=1, start, run 10 cycles -> count 3,2,1,3,2,1,3,2,1,3…; tc pulses every 3rd cycle; busy stays 1.
- Pause/stop: load 8, start, pause for 4 cycles after count=6 -> count holds 6 and busy=1. Release -> counting resumes at 5. stop at count=3 -> IDLE, count=3, no tc. start -> tc arrives 3 cycles later.
- Illegal/priority: start with count=0 -> err pulse, state stays IDLE. load=1 and start=1 together (val 4) -> count=4, not busy. load 7 during RUN -> ignored.
- Mid-run reset: load 15, start, assert reset=0 at count=10 -> count=0, busy=0 next edge, no tc.

Source files
------------

// File: rtl/down_timer.sv
// down_timer: programmable, loadable down-counter with one-shot and
// auto-reload modes. A start value is loaded, counted down to zero while
// running, and a one-cycle terminal-count pulse (tc) marks each expiry.
// Counting can be paused (HOLD) or aborted (back to IDLE with the count held).
// Starting with a zero count is rejected with a one-cycle err pulse.
// All outputs come straight from registers.

module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,        // synchronous, active-low
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Saturating decrement: a zero count stays zero instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] val);
        logic [WIDTH-1:0] res;
        if (val == CNT_ZERO) begin
            res = CNT_ZERO;
        end else begin
            res = val - CNT_ONE;
        end
        return res;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;

    // Next-state logic for the state, count, reload value and output pulses.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // load wins over start; stop and pause have no effect here
                if (load) begin
                    reload_d = load_val;
                    count_d  = load_val;
                end else if (start) begin
                    if (count_q != CNT_ZERO) begin
                        // no decrement on the start edge itself
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // priority: stop > pause > decrement; load is ignored
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else if (count_q > CNT_ONE) begin
                    count_d = sat_dec(count_q);
                end else if (count_q == CNT_ONE) begin
                    // expiry edge: auto_reload is only looked at here
                    tc_d = 1'b1;
                    if (auto_reload && (reload_q != CNT_ZERO)) begin
                        count_d = reload_q;
                    end else begin
                        count_d = CNT_ZERO;
                        state_d = ST_IDLE;
                    end
                end else begin
                    // zero count while running cannot be reached; recover to IDLE
                    count_d = CNT_ZERO;
                    state_d = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    // resume without decrementing on the release edge
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = CNT_ZERO;
            end
        endcase

        // busy is registered alongside the state it reflects
        if ((state_d == ST_RUN) || (state_d == ST_HOLD)) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            tc_q     <= tc_d;
            err_q    <= err_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;
    assign err   = err_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed testbench for down_timer (WIDTH = 4). Inputs change #1 after a
// rising edge and outputs are checked there. Each check compares the packed
// observation {count, busy, tc, err} against a hand-computed vector.

module tb_down_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       pause;
    logic       stop;
    logic       auto_reload;
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic       err;

    int checks;
    int failures;

    down_timer #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .auto_reload(auto_reload),
        .count      (count),
        .busy       (busy),
        .tc         (tc),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, then settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp_v;
        reset = 1'b0; load = 1'b1; load_val = 4'd9;
        tick();
        tick();
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL reset: got {count,busy,tc,err}=%h expected %h", {count, busy, tc, err}, exp_v);
        end
        reset = 1'b1; load = 1'b0; load_val = 4'd0;
        tick();
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
    endtask

    task automatic test_one_shot();
        logic [6:0] exp_v;
        load = 1'b1; load_val = 4'd5;
        tick();
        load = 1'b0;
        exp_v = {4'd5, 1'b0, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL oneshot_load: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_v = {4'd5, 1'b1, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL oneshot_start: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_v = {4'(5 - i), (i != 5), (i == 5), 1'b0};
            checks++;
            if ({count, busy, tc, err} !== exp_v) begin
                failures++;
                $display("FAIL oneshot_cycle%0d: got %h expected %h", i, {count, busy, tc, err}, exp_v);
            end
        end
        tick();
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL oneshot_after: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
    endtask

    task automatic test_periodic();
        logic [6:0] exp_v;
        load = 1'b1; load_val = 4'd3; auto_reload = 1'b1;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        exp_v = {4'd3, 1'b1, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL periodic_start: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_v = {((i % 3) == 0) ? 4'd3 : 4'(3 - (i % 3)), 1'b1, ((i % 3) == 0), 1'b0};
            checks++;
            if ({count, busy, tc, err} !== exp_v) begin
                failures++;
                $display("FAIL periodic_cycle%0d: got %h expected %h", i, {count, busy, tc, err}, exp_v);
            end
        end
        // count is 2 here; abort holds it
        stop = 1'b1;
        tick();
        stop = 1'b0; auto_reload = 1'b0;
        exp_v = {4'd2, 1'b0, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL periodic_stop: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
    endtask

    task automatic test_pause_stop();
        logic [6:0] exp_v;
        load = 1'b1; load_val = 4'd8;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        exp_v = {4'd6, 1'b1, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL pause_pre: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({count, busy, tc, err} !== exp_v) begin
                failures++;
                $display("FAIL pause_hold%0d: got %h expected %h", i, {count, busy, tc, err}, exp_v);
            end
        end
        pause = 1'b0;
        tick();
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL pause_release: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        tick();
        exp_v = {4'd5, 1'b1, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL pause_resume: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        exp_v = {4'd3, 1'b0, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL stop_held: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        tick();
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL stop_idle: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_v = {4'(3 - i), (i != 3), (i == 3), 1'b0};
            checks++;
            if ({count, busy, tc, err} !== exp_v) begin
                failures++;
                $display("FAIL restart_cycle%0d: got %h expected %h", i, {count, busy, tc, err}, exp_v);
            end
        end
    endtask

    task automatic test_illegal_priority();
        logic [6:0] exp_v;
        // count is 0 here
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_v = {4'd0, 1'b0, 1'b0, 1'b1};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL illegal_err: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        tick();
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL illegal_err_clear: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        load = 1'b1; start = 1'b1; load_val = 4'd4;
        tick();
        load = 1'b0; start = 1'b0;
        exp_v = {4'd4, 1'b0, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL load_over_start: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        load = 1'b1; load_val = 4'd7;
        tick();
        load = 1'b0;
        exp_v = {4'd3, 1'b1, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL load_in_run: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        // reload value must still be 4, not 7
        auto_reload = 1'b1;
        tick();
        tick();
        tick();
        exp_v = {4'd4, 1'b1, 1'b1, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL reload_kept: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_midrun_reset();
        logic [6:0] exp_v;
        load = 1'b1; load_val = 4'd15;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        exp_v = {4'd10, 1'b1, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL midrun_pre: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL midrun_reset: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
        tick();
        checks++;
        if ({count, busy, tc, err} !== exp_v) begin
            failures++;
            $display("FAIL midrun_after: got %h expected %h", {count, busy, tc, err}, exp_v);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0; load = 1'b0; load_val = 4'd0; start = 1'b0;
        pause = 1'b0; stop = 1'b0; auto_reload = 1'b0;
        #1;
        test_reset();
        test_one_shot();
        test_periodic();
        test_pause_stop();
        test_illegal_priority();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
